// File: rtl/arb_mux.sv
// -----------------------------------------------------------------------------
// arb_mux
//   N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on
//   every input channel and on the output. The channel granted each cycle is
//   picked by a compile-time policy:
//     MODE 0 : external select (sel), no grant when sel >= N or channel idle
//     MODE 1 : round-robin, scan starts at the channel after the last winner
//     MODE 2 : fixed priority, lowest valid index wins
//   A single output register holds one word and provides backpressure.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (clears output register and ptr)
//   in_data   N*WIDTH packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid  per-channel valid
//   in_ready  per-channel ready, combinational, at most one bit set
//   sel       requested channel (MODE 0 only)
//   out_data  registered output word
//   out_valid output register holds a word
//   out_ready consumer accepts out_data this cycle
//   out_chan  source channel of out_data
// -----------------------------------------------------------------------------
module arb_mux #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int MODE  = 0,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_chan
);

    localparam logic [SELW-1:0] LAST = SELW'(N - 1);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  out_chan_q,  out_chan_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;

    logic             load;
    logic             gnt_vld;
    logic [SELW-1:0]  gnt_idx;
    logic             xfer;

    // Fold ptr+k back into 0..N-1; k < N so one subtraction is enough and
    // no divider is needed for non-power-of-2 N.
    function automatic int wrap(input int v);
        return (v >= N) ? v - N : v;
    endfunction

    // Output slot is free when empty or being drained this same cycle.
    assign load = !out_valid_q || out_ready;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        case (MODE)
            0: begin
                // Compare against each legal index so sel >= N simply matches nothing.
                for (int i = 0; i < N; i++) begin
                    if (sel == SELW'(i) && in_valid[i]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = SELW'(i);
                    end
                end
            end
            1: begin
                for (int k = 0; k < N; k++) begin
                    if (!gnt_vld && in_valid[wrap(int'(ptr_q) + k)]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = SELW'(wrap(int'(ptr_q) + k));
                    end
                end
            end
            2: begin
                // Descending scan: the last hit is the lowest valid index.
                for (int i = N - 1; i >= 0; i--) begin
                    if (in_valid[i]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = SELW'(i);
                    end
                end
            end
            default: begin
                gnt_vld = 1'b0;
                gnt_idx = '0;
            end
        endcase
    end

    // rst_n gates ready directly so sources see no acceptance while in reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = rst_n && load && gnt_vld && (gnt_idx == SELW'(i));
        end
    end

    assign xfer = rst_n && load && gnt_vld;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (load) begin
            if (gnt_vld) begin
                out_data_d  = in_data[gnt_idx*WIDTH +: WIDTH];
                out_chan_d  = gnt_idx;
                out_valid_d = 1'b1;
            end else begin
                // Data and channel keep their last values; only valid drops.
                out_valid_d = 1'b0;
            end
        end
        if (MODE == 1 && xfer) begin
            ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_arb_mux.sv
// -----------------------------------------------------------------------------
// tb_arb_mux
//   Five arb_mux instances sharing clock and reset:
//     A : MODE 0, N=4   (select, backpressure, async reset)
//     B : MODE 1, N=4   (round-robin, restart after reset)
//     C : MODE 1, N=3   (non-power-of-2 round-robin)
//     D : MODE 2, N=4   (fixed priority / starvation)
//     E : MODE 0, N=3   (out-of-range select)
//   Expected words are queued when stimulus is applied; monitors pop and
//   compare whenever an output word is consumed.
// -----------------------------------------------------------------------------
module tb_arb_mux;

    logic clk;
    logic rst_n;

    int n_total;
    int n_pass;

    // A
    logic [63:0] a_data;
    logic [3:0]  a_valid, a_ready;
    logic [1:0]  a_sel, a_chan;
    logic [15:0] a_od;
    logic        a_ov, a_oready;
    // B
    logic [63:0] b_data;
    logic [3:0]  b_valid, b_ready;
    logic [1:0]  b_sel, b_chan;
    logic [15:0] b_od;
    logic        b_ov, b_oready;
    // C
    logic [47:0] c_data;
    logic [2:0]  c_valid, c_ready;
    logic [1:0]  c_sel, c_chan;
    logic [15:0] c_od;
    logic        c_ov, c_oready;
    // D
    logic [63:0] d_data;
    logic [3:0]  d_valid, d_ready;
    logic [1:0]  d_sel, d_chan;
    logic [15:0] d_od;
    logic        d_ov, d_oready;
    // E
    logic [47:0] e_data;
    logic [2:0]  e_valid, e_ready;
    logic [1:0]  e_sel, e_chan;
    logic [15:0] e_od;
    logic        e_ov, e_oready;

    // Expected words: {16-bit channel, 16-bit data}
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] qc[$];
    logic [31:0] qd[$];
    logic [31:0] ea, eb, ec, ed;

    arb_mux #(.WIDTH(16), .N(4), .MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_ready), .sel(a_sel), .out_data(a_od), .out_valid(a_ov),
        .out_ready(a_oready), .out_chan(a_chan));

    arb_mux #(.WIDTH(16), .N(4), .MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .sel(b_sel), .out_data(b_od), .out_valid(b_ov),
        .out_ready(b_oready), .out_chan(b_chan));

    arb_mux #(.WIDTH(16), .N(3), .MODE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid),
        .in_ready(c_ready), .sel(c_sel), .out_data(c_od), .out_valid(c_ov),
        .out_ready(c_oready), .out_chan(c_chan));

    arb_mux #(.WIDTH(16), .N(4), .MODE(2)) u_d (
        .clk(clk), .rst_n(rst_n), .in_data(d_data), .in_valid(d_valid),
        .in_ready(d_ready), .sel(d_sel), .out_data(d_od), .out_valid(d_ov),
        .out_ready(d_oready), .out_chan(d_chan));

    arb_mux #(.WIDTH(16), .N(3), .MODE(0)) u_e (
        .clk(clk), .rst_n(rst_n), .in_data(e_data), .in_valid(e_valid),
        .in_ready(e_ready), .sel(e_sel), .out_data(e_od), .out_valid(e_ov),
        .out_ready(e_oready), .out_chan(e_chan));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic no_word(input string nm, input logic [1:0] ch, input logic [15:0] dat);
        n_total++;
        $display("FAIL %s: unexpected word chan %0d data %h, required none", nm, ch, dat);
    endtask

    // Monitors: a word is consumed on the edge following a sample with valid && ready.
    always @(negedge clk) begin
        if (rst_n && a_ov && a_oready) begin
            if (qa.size() == 0) no_word("sb_a", a_chan, a_od);
            else begin
                ea = qa.pop_front();
                check("sb_a_chan", 32'(a_chan), 32'(ea[31:16]));
                check("sb_a_data", 32'(a_od),   32'(ea[15:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_ov && b_oready) begin
            if (qb.size() == 0) no_word("sb_b", b_chan, b_od);
            else begin
                eb = qb.pop_front();
                check("sb_b_chan", 32'(b_chan), 32'(eb[31:16]));
                check("sb_b_data", 32'(b_od),   32'(eb[15:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && c_ov && c_oready) begin
            if (qc.size() == 0) no_word("sb_c", c_chan, c_od);
            else begin
                ec = qc.pop_front();
                check("sb_c_chan", 32'(c_chan), 32'(ec[31:16]));
                check("sb_c_data", 32'(c_od),   32'(ec[15:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && d_ov && d_oready) begin
            if (qd.size() == 0) no_word("sb_d", d_chan, d_od);
            else begin
                ed = qd.pop_front();
                check("sb_d_chan", 32'(d_chan), 32'(ed[31:16]));
                check("sb_d_data", 32'(d_od),   32'(ed[15:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        a_data = '0; a_valid = 4'hF; a_sel = 2'd2; a_oready = 1'b1;
        b_data = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
        b_valid = 4'hF; b_sel = '0; b_oready = 1'b1;
        c_data = {16'hC002, 16'hC001, 16'hC000};
        c_valid = '0; c_sel = '0; c_oready = 1'b1;
        d_data = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
        d_valid = '0; d_sel = '0; d_oready = 1'b1;
        e_data = {16'hE002, 16'hE001, 16'hE000};
        e_valid = '0; e_sel = '0; e_oready = 1'b1;

        // Reset state, with requests pending that must not be accepted
        #2;
        check("rst_a_ov",    32'(a_ov),    32'd0);
        check("rst_a_od",    32'(a_od),    32'd0);
        check("rst_a_chan",  32'(a_chan),  32'd0);
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_b_ready", 32'(b_ready), 32'd0);
        tick;
        tick;
        check("rst_a_ov_edge", 32'(a_ov), 32'd0);
        a_valid = '0;
        b_valid = '0;
        rst_n   = 1'b1;
        tick;

        // MODE 0: select channel 2
        a_data[2*16 +: 16] = 16'hBEEF;
        a_valid = 4'b0100;
        a_sel   = 2'd2;
        qa.push_back({16'd2, 16'hBEEF});
        #1;
        check("m0_ready_sel2", 32'(a_ready), 32'b0100);
        tick;
        a_valid = '0;
        a_sel   = 2'd1;
        #1;
        check("m0_ov",        32'(a_ov),    32'd1);
        check("m0_od",        32'(a_od),    32'hBEEF);
        check("m0_chan",      32'(a_chan),  32'd2);
        check("m0_ready_sel1",32'(a_ready), 32'd0);
        tick;
        check("m0_ov_drop",   32'(a_ov),    32'd0);
        check("m0_od_hold",   32'(a_od),    32'hBEEF);
        check("m0_chan_hold", 32'(a_chan),  32'd2);

        // Backpressure
        a_data[0 +: 16] = 16'h1234;
        a_valid = 4'b0001;
        a_sel   = 2'd0;
        qa.push_back({16'd0, 16'h1234});
        tick;
        a_data[0 +: 16] = 16'h5678;
        a_oready = 1'b0;
        qa.push_back({16'd0, 16'h5678});
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ov",    32'(a_ov),    32'd1);
            check("bp_od",    32'(a_od),    32'h1234);
            check("bp_ready", 32'(a_ready), 32'd0);
            if (i < 2) tick;
        end
        a_oready = 1'b1;
        #1;
        check("bp_ready_drain", 32'(a_ready), 32'b0001);
        tick;
        a_valid = '0;
        #1;
        check("bp_ov_nobubble", 32'(a_ov), 32'd1);
        check("bp_od_next",     32'(a_od), 32'h5678);
        tick;
        check("bp_ov_empty",    32'(a_ov), 32'd0);

        // MODE 1, N=4: all channels valid continuously
        b_valid = 4'hF;
        for (int k = 0; k < 6; k++) qb.push_back({16'(k % 4), 16'hB000 + 16'(k % 4)});
        #1;
        check("rr4_ready_first", 32'(b_ready), 32'b0001);
        for (int k = 0; k < 6; k++) begin
            tick;
            if (k == 5) b_valid = '0;
            check("rr4_no_idle", 32'(b_ov), 32'd1);
        end
        tick;
        check("rr4_ov_empty", 32'(b_ov), 32'd0);

        // MODE 1, N=3: channels 0 and 2 alternate
        c_valid = 3'b101;
        qc.push_back({16'd0, 16'hC000});
        qc.push_back({16'd2, 16'hC002});
        qc.push_back({16'd0, 16'hC000});
        qc.push_back({16'd2, 16'hC002});
        #1;
        check("rr3_ready0", 32'(c_ready), 32'b001);
        for (int k = 0; k < 4; k++) begin
            tick;
            if (k == 3) c_valid = '0;
            #1;
            check("rr3_ptr_range", 32'(u_c.ptr_q < 2'd3), 32'd1);
            if (k < 3) check("rr3_ready", 32'(c_ready), (k % 2 == 0) ? 32'b100 : 32'b001);
        end
        tick;

        // MODE 2: channel 1 starves channel 3
        d_valid = 4'b1010;
        qd.push_back({16'd1, 16'hD001});
        qd.push_back({16'd1, 16'hD001});
        qd.push_back({16'd1, 16'hD001});
        qd.push_back({16'd3, 16'hD003});
        #1;
        check("prio_ready_c1", 32'(d_ready), 32'b0010);
        for (int k = 0; k < 4; k++) begin
            tick;
            if (k == 2) d_valid = 4'b1000;
            if (k == 3) d_valid = '0;
            #1;
            if (k < 2)  check("prio_ready_c1", 32'(d_ready), 32'b0010);
            if (k == 2) check("prio_ready_c3", 32'(d_ready), 32'b1000);
        end
        tick;

        // MODE 0, N=3: sel beyond the last channel never grants
        e_valid = 3'b111;
        e_sel   = 2'd3;
        #1;
        check("sel_oob_ready", 32'(e_ready), 32'd0);
        tick;
        check("sel_oob_ov", 32'(e_ov), 32'd0);
        e_sel = 2'd2;
        #1;
        check("sel2_ready", 32'(e_ready), 32'b100);
        tick;
        e_valid = '0;
        #1;
        check("sel2_ov",   32'(e_ov),   32'd1);
        check("sel2_od",   32'(e_od),   32'hE002);
        check("sel2_chan", 32'(e_chan), 32'd2);

        // Mid-stream asynchronous reset with a word held in A
        tick;
        a_data[3*16 +: 16] = 16'hAAAA;
        a_valid  = 4'b1000;
        a_sel    = 2'd3;
        a_oready = 1'b0;
        tick;
        a_valid = '0;
        #1;
        check("mrst_pre_ov", 32'(a_ov), 32'd1);
        rst_n   = 1'b0;
        a_valid = 4'b1000;
        b_valid = 4'hF;
        #1;
        check("mrst_ov",      32'(a_ov),    32'd0);
        check("mrst_od",      32'(a_od),    32'd0);
        check("mrst_chan",    32'(a_chan),  32'd0);
        check("mrst_a_ready", 32'(a_ready), 32'd0);
        check("mrst_b_ready", 32'(b_ready), 32'd0);
        tick;
        tick;
        a_valid = '0;
        a_oready = 1'b1;
        rst_n = 1'b1;
        // B left ptr at 2 before reset; restart must begin at channel 0
        qb.push_back({16'd0, 16'hB000});
        #1;
        check("post_rst_b_ready", 32'(b_ready), 32'b0001);
        tick;
        b_valid = '0;
        #1;
        check("post_rst_b_ov",   32'(b_ov),   32'd1);
        check("post_rst_b_chan", 32'(b_chan), 32'd0);
        tick;
        tick;

        check("qa_drained", 32'(qa.size()), 32'd0);
        check("qb_drained", 32'(qb.size()), 32'd0);
        check("qc_drained", 32'(qc.size()), 32'd0);
        check("qd_drained", 32'(qd.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
